// File: rtl/shift_reg_ctrl_if.sv
// rtl/shift_reg_ctrl_if.sv - start/data/serial/status bundle between a parallel client and the shift controller
interface shift_reg_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             si;
    logic             hold;
    logic             abort;
    logic             so;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] rx_data;
    logic             busy;
    logic             done;
    logic             shift_en;

    modport master (
        output start, din, si, hold, abort,
        input  so, sr, rx_data, busy, done, shift_en
    );

    modport slave (
        input  start, din, si, hold, abort,
        output so, sr, rx_data, busy, done, shift_en
    );
endinterface

// File: rtl/shift_reg_ctrl.sv
// rtl/shift_reg_ctrl.sv - serial shift-register sequencer: load, shift out/in, done strobe, hold and abort
// Optional SHREG_CTRL_LSB_FIRST_EN selects right shifts with so taken from sr[0].
module shift_reg_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    shift_reg_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_nx;
    logic [WIDTH-1:0] rx_q;
    logic [WIDTH-1:0] rx_nx;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

`ifdef SHREG_CTRL_LSB_FIRST_EN
    assign shifted = {bus.si, sr_q[WIDTH-1:1]};
    assign bus.so  = sr_q[0];
`else
    assign shifted = {sr_q[WIDTH-2:0], bus.si};
    assign bus.so  = sr_q[WIDTH-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr_q  <= '0;
            cnt   <= '0;
            rx_q  <= '0;
        end else begin
            state <= state_nx;
            sr_q  <= sr_nx;
            cnt   <= cnt_nx;
            rx_q  <= rx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sr_nx    = sr_q;
        cnt_nx   = cnt;
        rx_nx    = rx_q;
        case (state)
            // DONE accepts a new start directly so back-to-back words have no idle gap
            IDLE, DONE: begin
                if (bus.start && !bus.abort) begin
                    sr_nx    = bus.din;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end else begin
                    state_nx = IDLE;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    sr_nx    = '0;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (!bus.hold) begin
                    sr_nx = shifted;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        rx_nx    = shifted;
                        cnt_nx   = '0;
                        state_nx = DONE;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = (state == DONE);
    assign bus.shift_en = (state == SHIFT) && !bus.hold && !bus.abort;
    assign bus.sr       = sr_q;
    assign bus.rx_data  = rx_q;
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb/tb_shift_reg_ctrl.sv - randomized self-checking bench for shift_reg_ctrl against a transfer-level model
module tb_shift_reg_ctrl;
    localparam int W = 4;
`ifdef SHREG_CTRL_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    shift_reg_ctrl_if #(.WIDTH(W)) bus ();
    shift_reg_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Observations from the most recent transfer; so_t bit k is so during the k-th active shift.
    logic [W-1:0] so_t;
    logic [W-1:0] rx_obs;
    logic [W-1:0] sr_obs;
    logic [W-1:0] rx_model;
    logic [31:0]  so_all;
    logic [31:0]  se_all;
    logic         done_obs;
    int           edges;
    int           busy_cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] exp_so(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) r[k] = LSB ? d[k] : d[W-1-k];
        return r;
    endfunction

    function automatic logic [W-1:0] exp_rx(input logic [W-1:0] si_t);
        logic [W-1:0] r;
        for (int j = 0; j < W; j++) begin
            if (LSB) r[j] = si_t[j];
            else     r[W-1-j] = si_t[j];
        end
        return r;
    endfunction

    function automatic int exp_edges(input logic [31:0] hv);
        int n = 0;
        int c = 0;
        while (n < W) begin
            if (c >= 32 || !hv[c]) n++;
            c++;
        end
        return c + 1;
    endfunction

    function automatic logic [31:0] exp_se(input logic [31:0] hv);
        logic [31:0] r = '0;
        int n = 0;
        int c = 0;
        while (n < W) begin
            if (c >= 32 || !hv[c]) begin
                if (c < 32) r[c] = 1'b1;
                n++;
            end
            c++;
        end
        return r;
    endfunction

    // Drives one transfer from IDLE or DONE; start_mode 0=low, 1=held high, 2=random during SHIFT.
    task automatic xfer(input logic [W-1:0] d, input logic [W-1:0] si_t, input logic [31:0] hv,
                        input int start_mode, input int abort_c);
        int k = 0;
        int c = 0;
        so_t = '0; so_all = '0; se_all = '0;
        bus.din = d; bus.start = 1'b1; bus.abort = 1'b0; bus.hold = 1'b0;
        tick();
        edges = 1;
        bus.din = W'($urandom);
        while (bus.busy && c < 48) begin
            bus.start = (start_mode == 1) ? 1'b1 : (start_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.hold  = (c < 32) ? hv[c] : 1'b0;
            bus.abort = (c == abort_c);
            bus.si    = (bus.hold || k >= W) ? 1'($urandom_range(0, 1)) : si_t[k];
            #1;
            if (c < 32) begin
                so_all[c] = bus.so;
                se_all[c] = bus.shift_en;
            end
            if (!bus.hold && !bus.abort && k < W) so_t[k] = bus.so;
            tick();
            edges++;
            if (!bus.hold && !bus.abort) k++;
            c++;
        end
        bus.abort = 1'b0; bus.hold = 1'b0;
        busy_cyc = c; done_obs = bus.done; rx_obs = bus.rx_data; sr_obs = bus.sr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.sr !== '0)      begin errors++; $display("FAIL reset_sr got=%h exp=0", bus.sr); end
        checks++; if (bus.rx_data !== '0) begin errors++; $display("FAIL reset_rx got=%h exp=0", bus.rx_data); end
        checks++; if ({bus.so, bus.busy, bus.done, bus.shift_en} !== 4'b0)
            begin errors++; $display("FAIL reset_flags got=%b exp=0000", {bus.so, bus.busy, bus.done, bus.shift_en}); end
        rst = 1'b0;
        rx_model = '0;
    endtask

    task automatic test_basic();
        logic [W-1:0] so_c = LSB ? 4'b1011 : 4'b1101;
        logic [W-1:0] rx_c = LSB ? 4'b0100 : 4'b0010;
        xfer(4'b1011, 4'b0100, 32'h0, 0, -1);
        checks++; if (so_t !== so_c)    begin errors++; $display("FAIL basic_so got=%b exp=%b", so_t, so_c); end
        checks++; if (rx_obs !== rx_c)  begin errors++; $display("FAIL basic_rx got=%b exp=%b", rx_obs, rx_c); end
        checks++; if (done_obs !== 1'b1) begin errors++; $display("FAIL basic_done got=%b exp=1", done_obs); end
        checks++; if (edges != W + 1)   begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", edges, W + 1); end
        checks++; if (busy_cyc != W)    begin errors++; $display("FAIL basic_busy got=%0d exp=%0d", busy_cyc, W); end
        checks++; if (se_all !== 32'hF) begin errors++; $display("FAIL basic_shift_en got=%h exp=f", se_all); end
        checks++; if (sr_obs !== rx_c)  begin errors++; $display("FAIL basic_sr got=%b exp=%b", sr_obs, rx_c); end
        rx_model = rx_c;
        bus.start = 1'b0;
        tick();
        checks++; if ({bus.done, bus.busy} !== 2'b00)
            begin errors++; $display("FAIL basic_done_width got=%b exp=00", {bus.done, bus.busy}); end
    endtask

    task automatic test_reset_mid();
        bus.din = 4'b1111; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.si = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.sr !== '0)      begin errors++; $display("FAIL midrst_sr got=%h exp=0", bus.sr); end
        checks++; if (bus.rx_data !== '0) begin errors++; $display("FAIL midrst_rx got=%h exp=0", bus.rx_data); end
        checks++; if ({bus.so, bus.busy, bus.done} !== 3'b0)
            begin errors++; $display("FAIL midrst_flags got=%b exp=000", {bus.so, bus.busy, bus.done}); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got=%b exp=0", bus.busy); end
        rx_model = '0;
    endtask

    task automatic test_hold();
        logic [W-1:0] d = 4'b1011;
        logic [W-1:0] so_m = exp_so(d);
        xfer(d, 4'b0100, 32'hC, 0, -1);
        checks++; if (edges != W + 3)  begin errors++; $display("FAIL hold_latency got=%0d exp=%0d", edges, W + 3); end
        checks++; if (se_all !== 32'h33) begin errors++; $display("FAIL hold_shift_en got=%h exp=33", se_all); end
        checks++; if (so_all[2] !== so_m[2] || so_all[3] !== so_m[2])
            begin errors++; $display("FAIL hold_so got=%b%b exp=%b%b", so_all[3], so_all[2], so_m[2], so_m[2]); end
        checks++; if (so_t !== so_m)   begin errors++; $display("FAIL hold_so_seq got=%b exp=%b", so_t, so_m); end
        checks++; if (rx_obs !== exp_rx(4'b0100) || done_obs !== 1'b1)
            begin errors++; $display("FAIL hold_rx got=%b/%b exp=%b/1", rx_obs, done_obs, exp_rx(4'b0100)); end
        rx_model = exp_rx(4'b0100);
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        xfer(4'b1011, W'($urandom), 32'h0, 0, 2);
        checks++; if (done_obs !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done_obs); end
        checks++; if (sr_obs !== '0)     begin errors++; $display("FAIL abort_sr got=%h exp=0", sr_obs); end
        checks++; if (rx_obs !== rx_model) begin errors++; $display("FAIL abort_rx got=%b exp=%b", rx_obs, rx_model); end
        checks++; if (edges != 4)        begin errors++; $display("FAIL abort_latency got=%0d exp=4", edges); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_nodone got=%b exp=0", bus.done); end
        bus.start = 1'b1; bus.abort = 1'b1; bus.din = 4'b1111;
        tick();
        checks++; if ({bus.busy, bus.sr} !== {1'b0, 4'h0})
            begin errors++; $display("FAIL abort_idle_start got=%b/%h exp=0/0", bus.busy, bus.sr); end
        bus.abort = 1'b0;
        xfer(4'b0110, 4'b1001, 32'h0, 0, -1);
        rx_model = exp_rx(4'b1001);
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        checks++; if ({bus.busy, bus.done} !== 2'b00)
            begin errors++; $display("FAIL abort_done_start got=%b exp=00", {bus.busy, bus.done}); end
        bus.start = 1'b0; bus.abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] si2 = W'($urandom);
        xfer(W'($urandom), W'($urandom), 32'h0, 1, -1);
        checks++; if (done_obs !== 1'b1 || bus.start !== 1'b1)
            begin errors++; $display("FAIL b2b_first_done got=%b exp=1", done_obs); end
        xfer(4'b0101, si2, 32'h0, 0, -1);
        checks++; if (edges != W + 1 || done_obs !== 1'b1)
            begin errors++; $display("FAIL b2b_latency got=%0d/%b exp=%0d/1", edges, done_obs, W + 1); end
        checks++; if (so_t !== exp_so(4'b0101)) begin errors++; $display("FAIL b2b_so got=%b exp=%b", so_t, exp_so(4'b0101)); end
        checks++; if (rx_obs !== exp_rx(si2))   begin errors++; $display("FAIL b2b_rx got=%b exp=%b", rx_obs, exp_rx(si2)); end
        rx_model = exp_rx(si2);
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] d   = W'($urandom);
            logic [W-1:0] si  = W'($urandom);
            logic [31:0]  hv  = $urandom & $urandom;
            int           ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            int           sm  = ($urandom_range(0, 1) == 0) ? 0 : 2;
            xfer(d, si, hv, sm, ab);
            if (ab >= 0) begin
                checks++; if (done_obs !== 1'b0 || sr_obs !== '0 || rx_obs !== rx_model || edges != ab + 2)
                    begin errors++; $display("FAIL rand_abort[%0d] got=%b/%h/%b/%0d exp=0/0/%b/%0d",
                                             i, done_obs, sr_obs, rx_obs, edges, rx_model, ab + 2); end
            end else begin
                rx_model = exp_rx(si);
                checks++; if (done_obs !== 1'b1 || edges != exp_edges(hv))
                    begin errors++; $display("FAIL rand_latency[%0d] got=%b/%0d exp=1/%0d", i, done_obs, edges, exp_edges(hv)); end
                checks++; if (so_t !== exp_so(d))
                    begin errors++; $display("FAIL rand_so[%0d] got=%b exp=%b", i, so_t, exp_so(d)); end
                checks++; if (rx_obs !== rx_model)
                    begin errors++; $display("FAIL rand_rx[%0d] got=%b exp=%b", i, rx_obs, rx_model); end
                checks++; if (se_all !== exp_se(hv))
                    begin errors++; $display("FAIL rand_shift_en[%0d] got=%h exp=%h", i, se_all, exp_se(hv)); end
            end
            bus.start = 1'b0;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.din = '0; bus.si = 1'b0; bus.hold = 1'b0; bus.abort = 1'b0;
        test_reset();
        test_basic();
        test_reset_mid();
        test_hold();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
